line_burst_adaptor: RTL and testbench

Responder end of the L1 line-request interface: accepts one 256-bit line read or write request from the arbiter's downstream port and answers it with a single-cycle `mem_resp`. It converts each line into a 4-beat, 64-bit burst toward physical memory. It sits between the arbiter and main memory, in place of the L2 cache, in the no-L2 configuration.

---
 rtl/line_burst_adaptor_pkg.sv | 37 +++
 rtl/line_burst_adaptor_if.sv | 25 ++
 rtl/line_burst_adaptor_line_buffer.sv | 58 +++++
 rtl/line_burst_adaptor.sv | 162 ++++++++++++++++
 tb/tb_line_burst_adaptor.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/line_burst_adaptor_pkg.sv
// l1_cache_types: shared request/feedback structs, burst geometry constants
// and the adaptor state type used by line_burst_adaptor and line_buffer.
package l1_cache_types;

  localparam int BURST_BEATS      = 4;
  localparam int BEAT_WIDTH       = 64;
  localparam int LINE_OFFSET_BITS = 5;
  localparam int LINE_WIDTH       = BURST_BEATS * BEAT_WIDTH;

  typedef struct packed {
    logic                  mem_read;
    logic                  mem_write;
    logic [31:0]           mem_addr;
    logic [LINE_WIDTH-1:0] mem_wdata256;
  } l1_cache_request;

  typedef struct packed {
    logic                  mem_resp;
    logic [LINE_WIDTH-1:0] mem_rdata256;
  } l1_cache_feedback;

  typedef enum logic [2:0] {
    IDLE,
    RBURST,
    WBURST,
    RESP,
    DONE
  } burst_state_t;

  typedef logic [31:LINE_OFFSET_BITS] line_tag_t;

  // Line-aligned base address: offset bits within the 32-byte line cleared.
  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return {addr[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/line_burst_adaptor_if.sv
// line_burst_adaptor_if: arbiter-side line request/feedback plus the
// memory-side burst signals. slave = the adaptor, master = its environment.
interface line_burst_adaptor_if;
  import l1_cache_types::*;

  l1_cache_request  line_request;
  l1_cache_feedback line_feedback;
  logic [BEAT_WIDTH-1:0] burst_rdata;
  logic [BEAT_WIDTH-1:0] burst_wdata;
  logic [31:0]           burst_addr;
  logic                  burst_read;
  logic                  burst_write;
  logic                  burst_resp;

  modport slave (
    input  line_request, burst_rdata, burst_resp,
    output line_feedback, burst_wdata, burst_addr, burst_read, burst_write
  );

  modport master (
    output line_request, burst_rdata, burst_resp,
    input  line_feedback, burst_wdata, burst_addr, burst_read, burst_write
  );

endinterface

// File: rtl/line_burst_adaptor_line_buffer.sv
// line_buffer: one buffered 256-bit line (tag, valid, data). Filled by a
// completed read burst, overwritten by a write to the same line, looked up
// combinationally for read hits. Used only when LINE_BUFFER_EN is defined.
module line_buffer
  import l1_cache_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  line_tag_t             lookup_tag,
  output logic                  hit,
  output logic [LINE_WIDTH-1:0] rdata,
  input  logic                  fill_en,
  input  line_tag_t             fill_tag,
  input  logic [LINE_WIDTH-1:0] fill_data,
  input  logic                  update_en,
  input  logic [LINE_WIDTH-1:0] update_data
);

  line_tag_t             tag_q, tag_d;
  logic                  valid_q, valid_d;
  logic [LINE_WIDTH-1:0] data_q, data_d;

  assign hit   = valid_q && (tag_q == lookup_tag);
  assign rdata = data_q;

  // Next tag/valid/data: a fill replaces the whole entry, an update only the data.
  always_comb begin
    tag_d   = tag_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (fill_en) begin
      tag_d   = fill_tag;
      valid_d = 1'b1;
      data_d  = fill_data;
    end else if (update_en) begin
      data_d  = update_data;
    end
  end

  // Tag and valid are reset so the buffer starts empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end

  // Line data storage.
  // NOTE: data is deliberately not reset; valid_q gates every use, so a reset
  // here would only add fan-out on 256 flops for no functional gain.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule

// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor: answers one 256-bit line read/write from the arbiter
// with a single-cycle mem_resp, converting it into a 4-beat 64-bit memory
// burst. Optional feature macro: LINE_BUFFER_EN adds a one-line read buffer
// (read hits answered without memory traffic, writes are written through).
module line_burst_adaptor
  import l1_cache_types::*;
(
  input  logic clk,
  input  logic rst,
  line_burst_adaptor_if.slave bus
);

  localparam int BEATS = BURST_BEATS;

  burst_state_t          state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
  logic                  resp_q, resp_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic                  last_beat;

  assign last_beat = (cnt_q == 2'(BEATS - 1));

`ifdef LINE_BUFFER_EN
  logic                  buf_hit;
  logic [LINE_WIDTH-1:0] buf_rdata;
  logic                  fill_en;
  logic                  update_en;

  line_buffer u_line_buffer (
    .clk         (clk),
    .rst         (rst),
    .lookup_tag  (bus.line_request.mem_addr[31:LINE_OFFSET_BITS]),
    .hit         (buf_hit),
    .rdata       (buf_rdata),
    .fill_en     (fill_en),
    .fill_tag    (addr_q[31:LINE_OFFSET_BITS]),
    .fill_data   (rdata_d),
    .update_en   (update_en),
    .update_data (bus.line_request.mem_wdata256)
  );
`endif

  // Next-state and next-output logic for the request/burst sequence.
  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    resp_d  = 1'b0;
    read_d  = read_q;
    write_d = write_q;
`ifdef LINE_BUFFER_EN
    fill_en   = 1'b0;
    update_en = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        // Reads win over writes when both are requested.
        if (bus.line_request.mem_read) begin
          addr_d = line_base(bus.line_request.mem_addr);
          cnt_d  = '0;
`ifdef LINE_BUFFER_EN
          if (buf_hit) begin
            rdata_d = buf_rdata;
            resp_d  = 1'b1;
            state_d = RESP;
          end else begin
            read_d  = 1'b1;
            state_d = RBURST;
          end
`else
          read_d  = 1'b1;
          state_d = RBURST;
`endif
        end else if (bus.line_request.mem_write) begin
          addr_d  = line_base(bus.line_request.mem_addr);
          wdata_d = bus.line_request.mem_wdata256;
          cnt_d   = '0;
          write_d = 1'b1;
          state_d = WBURST;
`ifdef LINE_BUFFER_EN
          update_en = buf_hit;
`endif
        end
      end

      RBURST: begin
        // burst_resp low simply holds cnt, so stalls lose no beats.
        if (bus.burst_resp) begin
          rdata_d[BEAT_WIDTH*int'(cnt_q) +: BEAT_WIDTH] = bus.burst_rdata;
          cnt_d = cnt_q + 2'd1;
          if (last_beat) begin
            read_d  = 1'b0;
            resp_d  = 1'b1;
            state_d = RESP;
`ifdef LINE_BUFFER_EN
            fill_en = 1'b1;
`endif
          end
        end
      end

      WBURST: begin
        if (bus.burst_resp) begin
          cnt_d = cnt_q + 2'd1;
          if (last_beat) begin
            write_d = 1'b0;
            resp_d  = 1'b1;
            state_d = RESP;
          end
        end
      end

      // One-cycle response, then one recovery cycle that ignores the
      // request inputs while the arbiter sets up its prefetch.
      RESP:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any burst in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge
    // values, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      read_q  <= read_d;
      write_q <= write_d;
    end
  end

  assign bus.line_feedback.mem_resp     = resp_q;
  assign bus.line_feedback.mem_rdata256 = rdata_q;
  assign bus.burst_addr                 = addr_q;
  assign bus.burst_read                 = read_q;
  assign bus.burst_write                = write_q;
  assign bus.burst_wdata                = wdata_q[BEAT_WIDTH*int'(cnt_q) +: BEAT_WIDTH];

endmodule

// File: tb/tb_line_burst_adaptor.sv
// tb_line_burst_adaptor: directed tests for line_burst_adaptor with a
// transaction-level reference model compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_line_burst_adaptor;
  import l1_cache_types::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_burst_adaptor_if bus ();

  line_burst_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model state ----------------
  typedef enum {K_NONE, K_READ, K_WRITE, K_HIT} kind_e;
  kind_e        m_kind      = K_NONE;
  int           m_acc       = -100;
  int           m_start     = -100;
  int           m_end       = -100;
  int           m_resp      = -100;
  int           m_idle_at   = 0;
  logic [31:0]  m_addr      = '0;
  logic [31:0]  m_pat       = '1;
  logic [255:0] m_wline     = '0;
  logic [255:0] m_rline     = '0;
  logic [255:0] m_last_rdata = '0;
  logic [31:0]  ack_pat     = '1;
  bit           buf_valid   = 1'b0;
  logic [31:0]  buf_addr    = '0;
  logic [255:0] buf_data    = '0;
  logic [63:0]  mem [logic [31:0]];
  bit           cmp_en      = 1'b0;
  bit           junk_resp   = 1'b0;

  // observations
  int           resp_pulses = 0;
  int           rd_bursts   = 0;
  int           wr_bursts   = 0;
  bit           prev_rd     = 1'b0;
  bit           prev_wr     = 1'b0;
  logic [31:0]  obs_addr    = '0;
  logic [63:0]  obs_w [4];
  int           obs_wn      = 0;
  int           last_resp_cyc = -1;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a, ~a};
  endfunction

  function automatic bit pat_bit(input logic [31:0] pat, input int i);
    return (i < 32) ? pat[i] : 1'b1;
  endfunction

  // Number of acknowledged beats in pattern positions 0..n-1.
  function automatic int acks_before(input logic [31:0] pat, input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(pat_bit(pat, i));
    return s;
  endfunction

  // Pattern position of the 4th acknowledge.
  function automatic int last_ack_idx(input logic [31:0] pat);
    for (int i = 0; i < 64; i++)
      if (acks_before(pat, i + 1) == BURST_BEATS) return i;
    return 63;
  endfunction

  // Memory responder: acknowledges beats per the pattern while the model
  // says a burst is in progress; outside that it drives junk_resp.
  always @(posedge clk) begin : responder
    int i;
    #1;
    if ((m_kind == K_READ || m_kind == K_WRITE) && cyc >= m_start && cyc <= m_end) begin
      i = cyc - m_start;
      bus.burst_resp  = pat_bit(m_pat, i);
      bus.burst_rdata = mem_word(m_addr + 32'(8 * acks_before(m_pat, i)));
    end else begin
      bus.burst_resp  = junk_resp;
      bus.burst_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    end
  end

  // Compare DUT against the model, then advance the model for this cycle.
  always @(negedge clk) begin : model_cmp
    int          c;
    bit          in_burst;
    logic [31:0] base;
    c = cyc;
    in_burst = (m_kind == K_READ || m_kind == K_WRITE) && c >= m_start && c <= m_end;
    if (cmp_en) begin
      if (bus.line_feedback.mem_resp === 1'b1) begin
        resp_pulses++;
        last_resp_cyc = c;
      end
      if (bus.burst_read === 1'b1 && !prev_rd) begin
        rd_bursts++;
        obs_addr = bus.burst_addr;
      end
      if (bus.burst_write === 1'b1 && !prev_wr) wr_bursts++;
      if (bus.burst_write === 1'b1 && bus.burst_resp === 1'b1) begin
        obs_w[obs_wn % 4] = bus.burst_wdata;
        obs_wn++;
      end
      prev_rd = bus.burst_read;
      prev_wr = bus.burst_write;

      check("mem_resp", 256'(bus.line_feedback.mem_resp), 256'(c == m_resp));
      if (c == m_resp)
        check("mem_rdata256", bus.line_feedback.mem_rdata256,
              (m_kind == K_WRITE) ? m_last_rdata : m_rline);
      check("burst_read", 256'(bus.burst_read), 256'(in_burst && m_kind == K_READ));
      check("burst_write", 256'(bus.burst_write), 256'(in_burst && m_kind == K_WRITE));
      if (in_burst) check("burst_addr", 256'(bus.burst_addr), 256'(m_addr));
      if (in_burst && m_kind == K_WRITE)
        check("burst_wdata", 256'(bus.burst_wdata),
              256'(m_wline[64*acks_before(m_pat, c - m_start) +: 64]));
    end

    // A completed read becomes the held response data (and the buffered line).
    if (c == m_resp && (m_kind == K_READ || m_kind == K_HIT)) begin
      m_last_rdata = m_rline;
`ifdef LINE_BUFFER_EN
      if (m_kind == K_READ) begin
        buf_valid = 1'b1;
        buf_addr  = m_addr;
        buf_data  = m_rline;
      end
`endif
    end

    if (rst) begin
      m_kind       = K_NONE;
      m_resp       = -100;
      m_last_rdata = '0;
      buf_valid    = 1'b0;
      m_idle_at    = c + 1;
    end else if (c >= m_idle_at &&
                 (bus.line_request.mem_read || bus.line_request.mem_write)) begin
      base   = {bus.line_request.mem_addr[31:5], 5'b0};
      m_acc  = c;
      m_addr = base;
      m_pat  = ack_pat;
      if (bus.line_request.mem_read) begin
        if (buf_valid && buf_addr == base) begin
          m_kind    = K_HIT;
          m_rline   = buf_data;
          m_resp    = c + 1;
          m_idle_at = c + 3;
        end else begin
          m_kind  = K_READ;
          m_rline = {mem_word(base + 24), mem_word(base + 16),
                     mem_word(base + 8), mem_word(base)};
        end
      end else begin
        m_kind  = K_WRITE;
        m_wline = bus.line_request.mem_wdata256;
        for (int k = 0; k < 4; k++) mem[base + 32'(8 * k)] = m_wline[64*k +: 64];
        if (buf_valid && buf_addr == base) buf_data = m_wline;
      end
      if (m_kind != K_HIT) begin
        m_start   = c + 1;
        m_end     = c + 1 + last_ack_idx(m_pat);
        m_resp    = m_end + 1;
        m_idle_at = m_resp + 2;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_req(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [255:0] wd, input logic [31:0] pat,
                           output int acc);
    int t0;
    int n;
    t0 = cyc;
    n  = 0;
    ack_pat = pat;
    bus.line_request.mem_read     = rd;
    bus.line_request.mem_write    = wr;
    bus.line_request.mem_addr     = a;
    bus.line_request.mem_wdata256 = wd;
    while (m_acc < t0 && n < 50) begin
      tick();
      n++;
    end
    check("accept", 256'(m_acc >= t0), 256'(1));
    acc = m_acc;
  endtask

  // Drop the request and scramble its payload; the DUT must not care.
  task automatic drop_req();
    bus.line_request.mem_read     = 1'b0;
    bus.line_request.mem_write    = 1'b0;
    bus.line_request.mem_addr     = 32'hFFFF_FFE0;
    bus.line_request.mem_wdata256 = {8{32'hDEAD_BEEF}};
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((cyc <= m_resp || cyc < m_idle_at) && n < 100) begin
      tick();
      n++;
    end
    check("idle_reached", 256'(n < 100), 256'(1));
  endtask

  task automatic do_txn(input bit rd, input logic [31:0] a, input logic [255:0] wd,
                        input logic [31:0] pat, output int acc);
    start_req(rd, !rd, a, wd, pat, acc);
    drop_req();
    wait_idle();
  endtask

  localparam logic [255:0] T1_LINE =
    256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
  localparam logic [255:0] T2_LINE =
    256'h0F0FF0F012348765_A5A5A5A55A5A5A5A_FEDCBA9876543210_0123456789ABCDEF;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int acc, acc2, p0, r0, w0, n;
    logic [63:0] w2_beats [4];

    rst = 1'b1;
    bus.line_request = '0;
    bus.burst_resp   = 1'b0;
    bus.burst_rdata  = '0;
    repeat (3) tick();
    rst = 1'b0;
    cmp_en = 1'b1;

    // Reset state
    check("rst_mem_resp",    256'(bus.line_feedback.mem_resp), 256'(0));
    check("rst_mem_rdata",   bus.line_feedback.mem_rdata256, 256'(0));
    check("rst_burst_read",  256'(bus.burst_read), 256'(0));
    check("rst_burst_write", 256'(bus.burst_write), 256'(0));
    check("rst_burst_addr",  256'(bus.burst_addr), 256'(0));
    check("rst_burst_wdata", 256'(bus.burst_wdata), 256'(0));
    junk_resp = 1'b1;   // stray acks outside bursts must be ignored
    tick();

    // T1: basic read, back-to-back beats
    mem[32'h1220] = 64'h1111111111111111;
    mem[32'h1228] = 64'h2222222222222222;
    mem[32'h1230] = 64'h3333333333333333;
    mem[32'h1238] = 64'h4444444444444444;
    p0 = resp_pulses;
    do_txn(1'b1, 32'h0000_1234, '0, 32'hFFFF_FFFF, acc);
    check("t1_burst_addr", 256'(obs_addr), 256'(32'h0000_1220));
    check("t1_latency", 256'(last_resp_cyc - acc), 256'(5));
    check("t1_rdata", bus.line_feedback.mem_rdata256, T1_LINE);
    check("t1_pulses", 256'(resp_pulses - p0), 256'(1));

    // T2: write burst
    obs_wn = 0;
    w0 = wr_bursts;
    do_txn(1'b0, 32'h8000_0040, T2_LINE, 32'hFFFF_FFFF, acc);
    for (int i = 0; i < 4; i++) check("t2_wdata_beat", 256'(obs_w[i]), 256'(T2_LINE[64*i +: 64]));
    check("t2_beats", 256'(obs_wn), 256'(4));
    check("t2_latency", 256'(last_resp_cyc - acc), 256'(5));
    check("t2_bursts", 256'(wr_bursts - w0), 256'(1));
    check("t2_rdata_held", bus.line_feedback.mem_rdata256, T1_LINE);

    // T3: read with acknowledge gaps 1,0,0,1,1,0,1
    do_txn(1'b1, 32'h0000_2000, '0, 32'hFFFF_FFD9, acc);
    check("t3_latency", 256'(last_resp_cyc - acc), 256'(8));
    check("t3_rdata", bus.line_feedback.mem_rdata256,
          256'h00002018FFFFDFE7_00002010FFFFDFEF_00002008FFFFDFF7_00002000FFFFDFFF);

    // T4: mem_read held through RESP/DONE with the address moved to +32
    p0 = resp_pulses;
    r0 = rd_bursts;
    start_req(1'b1, 1'b0, 32'h0000_3000, '0, 32'hFFFF_FFFF, acc);
    bus.line_request.mem_addr = 32'h0000_3020;
    n = 0;
    while (m_acc == acc && n < 50) begin
      tick();
      n++;
    end
    acc2 = m_acc;
    check("t4_second_accept", 256'(acc2 - acc), 256'(7));
    drop_req();
    wait_idle();
    check("t4_pulses", 256'(resp_pulses - p0), 256'(2));
    check("t4_bursts", 256'(rd_bursts - r0), 256'(2));
    check("t4_last_addr", 256'(obs_addr), 256'(32'h0000_3020));

    // T5: reset after beat 2 of a read
    start_req(1'b1, 1'b0, 32'h0000_4000, '0, 32'h0000_0003, acc);
    drop_req();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_mem_resp",    256'(bus.line_feedback.mem_resp), 256'(0));
    check("t5_mem_rdata",   bus.line_feedback.mem_rdata256, 256'(0));
    check("t5_burst_read",  256'(bus.burst_read), 256'(0));
    check("t5_burst_write", 256'(bus.burst_write), 256'(0));
    check("t5_burst_addr",  256'(bus.burst_addr), 256'(0));
    check("t5_burst_wdata", 256'(bus.burst_wdata), 256'(0));
    p0 = resp_pulses;
    repeat (10) tick();
    check("t5_no_resp", 256'(resp_pulses - p0), 256'(0));
    do_txn(1'b1, 32'h0000_4000, '0, 32'hFFFF_FFFF, acc);
    check("t5_after_rdata", bus.line_feedback.mem_rdata256,
          256'h00004018FFFFBFE7_00004010FFFFBFEF_00004008FFFFBFF7_00004000FFFFBFFF);

    // T6: repeated read of one line, then write + read of that line
    do_txn(1'b1, 32'h0000_5000, '0, 32'hFFFF_FFFF, acc);
    r0 = rd_bursts;
    do_txn(1'b1, 32'h0000_5008, '0, 32'hFFFF_FFFF, acc);
    check("t6_rdata", bus.line_feedback.mem_rdata256,
          256'h00005018FFFFAFE7_00005010FFFFAFEF_00005008FFFFAFF7_00005000FFFFAFFF);
`ifdef LINE_BUFFER_EN
    check("t6_hit_latency", 256'(last_resp_cyc - acc), 256'(1));
    check("t6_hit_no_burst", 256'(rd_bursts - r0), 256'(0));
`else
    check("t6_miss_latency", 256'(last_resp_cyc - acc), 256'(5));
    check("t6_miss_burst", 256'(rd_bursts - r0), 256'(1));
`endif
    w2_beats[0] = 64'h0000_0000_0000_00A1;
    w2_beats[1] = 64'h0000_0000_0000_00B2;
    w2_beats[2] = 64'h0000_0000_0000_00C3;
    w2_beats[3] = 64'h0000_0000_0000_00D4;
    do_txn(1'b0, 32'h0000_5000, {w2_beats[3], w2_beats[2], w2_beats[1], w2_beats[0]},
           32'hFFFF_FFFF, acc);
    r0 = rd_bursts;
    do_txn(1'b1, 32'h0000_5010, '0, 32'hFFFF_FFFF, acc);
    check("t6_wr_rd_data", bus.line_feedback.mem_rdata256,
          256'h00000000000000D4_00000000000000C3_00000000000000B2_00000000000000A1);
`ifdef LINE_BUFFER_EN
    check("t6_wr_rd_no_burst", 256'(rd_bursts - r0), 256'(0));
`else
    check("t6_wr_rd_burst", 256'(rd_bursts - r0), 256'(1));
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
